// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared widths, instruction kinds and FSM encoding for alu_issue
package alu_issue_pkg;

  localparam int DATAW     = 16;
  localparam int REG_IDX_W = 2;

  typedef logic [DATAW-1:0]     databus_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    KIND_LDI = 1'b0,
    KIND_ALU = 1'b1
  } instr_kind_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - instruction stream handshake between a feeder and alu_issue
interface alu_issue_if
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = DATAW
);

  logic              valid;
  logic              ready;
  logic              kind;
  logic [1:0]        op;
  reg_idx_t          rd;
  reg_idx_t          rx;
  reg_idx_t          ry;
  logic [DATA_W-1:0] imm;

  modport master (output valid, kind, op, rd, rx, ry, imm, input ready);
  modport slave  (input valid, kind, op, rd, rx, ry, imm, output ready);

endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 4-entry operand register file, one write port, three async read ports
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = DATAW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  reg_idx_t          wa,
  input  logic [DATA_W-1:0] wd,
  input  reg_idx_t          ra_x,
  input  reg_idx_t          ra_y,
  input  reg_idx_t          ra_dbg,
  output logic [DATA_W-1:0] rd_x,
  output logic [DATA_W-1:0] rd_y,
  output logic [DATA_W-1:0] rd_dbg
);

  logic [3:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign rd_x   = mem[ra_x];
  assign rd_y   = mem[ra_y];
  assign rd_dbg = mem[ra_dbg];

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - instruction issue FSM feeding a fixed-latency 2-operand ALU
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DATA_W  = DATAW,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  alu_issue_if.slave        instr,
  output logic              alu_ena,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic              wb_valid,
  output reg_idx_t          wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  input  reg_idx_t          dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state, state_n;
  logic [2:0]        cnt, cnt_n;
  reg_idx_t          rd_q, rd_n;
  logic              alu_ena_n;
  logic [DATA_W-1:0] alu_x_n, alu_y_n;
  logic [1:0]        alu_op_n;
  logic              wb_valid_n;
  reg_idx_t          wb_rd_n;
  logic [DATA_W-1:0] wb_data_n;
  logic              we;
  reg_idx_t          wa;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rf_x, rf_y;
  logic              accept;

  assign instr.ready = ena && rst_n && (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = instr.valid && instr.ready;

  alu_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we && ena),
    .wa     (wa),
    .wd     (wd),
    .ra_x   (instr.rx),
    .ra_y   (instr.ry),
    .ra_dbg (dbg_addr),
    .rd_x   (rf_x),
    .rd_y   (rf_y),
    .rd_dbg (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_q     <= '0;
      alu_ena  <= 1'b0;
      alu_x    <= '0;
      alu_y    <= '0;
      alu_op   <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (ena) begin
      state    <= state_n;
      cnt      <= cnt_n;
      rd_q     <= rd_n;
      alu_ena  <= alu_ena_n;
      alu_x    <= alu_x_n;
      alu_y    <= alu_y_n;
      alu_op   <= alu_op_n;
      wb_valid <= wb_valid_n;
      wb_rd    <= wb_rd_n;
      wb_data  <= wb_data_n;
    end else begin
      wb_valid <= 1'b0;
    end
  end

  // Operands are captured from the register file at the accept edge, so an
  // instruction whose rd matches rx/ry always sees the old value.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rd_n       = rd_q;
    alu_ena_n  = 1'b0;
    alu_x_n    = alu_x;
    alu_y_n    = alu_y;
    alu_op_n   = alu_op;
    wb_valid_n = 1'b0;
    wb_rd_n    = wb_rd;
    wb_data_n  = wb_data;
    we         = 1'b0;
    wa         = rd_q;
    wd         = alu_res;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (instr.kind == KIND_LDI) begin
            we         = 1'b1;
            wa         = instr.rd;
            wd         = instr.imm;
            wb_valid_n = 1'b1;
            wb_rd_n    = instr.rd;
            wb_data_n  = instr.imm;
          end else begin
            rd_n      = instr.rd;
            alu_ena_n = 1'b1;
            alu_x_n   = rf_x;
            alu_y_n   = rf_y;
            alu_op_n  = instr.op;
            state_n   = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_n   = 3'(ALU_LAT);
        state_n = WAIT;
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          we         = 1'b1;
          wb_valid_n = 1'b1;
          wb_rd_n    = rd_q;
          wb_data_n  = alu_res;
          cnt_n      = '0;
          state_n    = IDLE;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - bench for alu_issue: directed cases plus a randomized stream against a timeline model
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam int W    = DATAW;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic ena1  = 1'b1;
  logic ena3  = 1'b1;

  alu_issue_if #(.DATA_W(W)) bus1 ();
  alu_issue_if #(.DATA_W(W)) bus3 ();

  logic         alu_ena1, alu_ena3, wb_valid1, wb_valid3, busy1, busy3;
  logic [W-1:0] alu_x1, alu_y1, alu_x3, alu_y3, wb_data1, wb_data3, dbg_data1, dbg_data3;
  logic [W-1:0] alu_res1 = '0;
  logic [W-1:0] alu_res3 = '0;
  logic [1:0]   alu_op1, alu_op3, wb_rd1, wb_rd3;
  logic [1:0]   dbg_addr1 = 2'd0;
  logic [1:0]   dbg_addr3 = 2'd0;

  alu_issue #(.DATA_W(W), .ALU_LAT(LAT1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena1), .instr(bus1),
    .alu_ena(alu_ena1), .alu_x(alu_x1), .alu_y(alu_y1), .alu_op(alu_op1), .alu_res(alu_res1),
    .wb_valid(wb_valid1), .wb_rd(wb_rd1), .wb_data(wb_data1), .busy(busy1),
    .dbg_addr(dbg_addr1), .dbg_data(dbg_data1)
  );

  alu_issue #(.DATA_W(W), .ALU_LAT(LAT3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena3), .instr(bus3),
    .alu_ena(alu_ena3), .alu_x(alu_x3), .alu_y(alu_y3), .alu_op(alu_op3), .alu_res(alu_res3),
    .wb_valid(wb_valid3), .wb_rd(wb_rd3), .wb_data(wb_data3), .busy(busy3),
    .dbg_addr(dbg_addr3), .dbg_data(dbg_data3)
  );

  function automatic logic [W-1:0] alu_f(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return x & y;
      default: return x | y;
    endcase
  endfunction

  // ALU stubs: result registered on the enable cycle and held afterwards
  always @(posedge clk) if (alu_ena1) alu_res1 <= alu_f(alu_op1, alu_x1, alu_y1);
  always @(posedge clk) if (alu_ena3) alu_res3 <= alu_f(alu_op3, alu_x3, alu_y3);

  int n_total = 0;
  int n_pass  = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Timeline model of dut1: cycle k is the cycle after the k-th counted edge
  int           cyc       = 0;
  int           idle_from = 0;
  int           acc_cyc   = -1;
  logic [W-1:0] mrf [4]   = '{default: '0};
  bit           pend      = 1'b0;
  int           pend_cyc  = 0;
  logic [1:0]   pend_rd   = '0;
  logic [W-1:0] pend_data = '0;
  bit           e_alu_ena = 1'b0;
  bit           e_wb_valid = 1'b0;
  logic [W-1:0] e_x = '0, e_y = '0, e_wb_data = '0;
  logic [1:0]   e_op = '0, e_wb_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mrf[i] = '0;
      pend = 1'b0; idle_from = 0;
      e_alu_ena = 1'b0; e_wb_valid = 1'b0;
      e_x = '0; e_y = '0; e_op = '0; e_wb_rd = '0; e_wb_data = '0;
    end else begin
      automatic bit rdy = (cyc >= idle_from);
      cyc = cyc + 1;
      e_alu_ena = 1'b0; e_wb_valid = 1'b0;
      if (pend && pend_cyc == cyc) begin
        mrf[pend_rd] = pend_data;
        e_wb_valid = 1'b1; e_wb_rd = pend_rd; e_wb_data = pend_data;
        pend = 1'b0;
      end
      if (rdy && bus1.valid) begin
        acc_cyc = cyc;
        if (bus1.kind == 1'b0) begin
          mrf[bus1.rd] = bus1.imm;
          e_wb_valid = 1'b1; e_wb_rd = bus1.rd; e_wb_data = bus1.imm;
        end else begin
          e_alu_ena = 1'b1;
          e_x = mrf[bus1.rx]; e_y = mrf[bus1.ry]; e_op = bus1.op;
          pend = 1'b1; pend_cyc = cyc + 1 + LAT1; pend_rd = bus1.rd;
          pend_data = alu_f(bus1.op, mrf[bus1.rx], mrf[bus1.ry]);
          idle_from = cyc + 1 + LAT1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("ready",    bus1.ready, rst_n && (cyc >= idle_from));
      chk("busy",     busy1,      cyc < idle_from);
      chk("alu_ena",  alu_ena1,   e_alu_ena);
      chk("alu_x",    alu_x1,     e_x);
      chk("alu_y",    alu_y1,     e_y);
      chk("alu_op",   alu_op1,    e_op);
      chk("wb_valid", wb_valid1,  e_wb_valid);
      chk("wb_rd",    wb_rd1,     e_wb_rd);
      chk("wb_data",  wb_data1,   e_wb_data);
      chk("dbg_data", dbg_data1,  mrf[dbg_addr1]);
    end
  end

  // Holds the instruction until the model sees it accepted; leaves valid high.
  task automatic send(input logic kind, input logic [1:0] op, input logic [1:0] rd,
                      input logic [1:0] rx, input logic [1:0] ry, input logic [W-1:0] imm);
    bit got = 1'b0;
    bus1.valid = 1'b1; bus1.kind = kind; bus1.op = op;
    bus1.rd = rd; bus1.rx = rx; bus1.ry = ry; bus1.imm = imm;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (acc_cyc == cyc) got = 1'b1;
    end
    if (!got) chk("accept_timeout", W'(got), W'(1));
  endtask

  task automatic stop();
    bus1.valid = 1'b0;
  endtask

  initial begin
    bus1.valid = 1'b0; bus1.kind = 1'b0; bus1.op = '0; bus1.rd = '0; bus1.rx = '0; bus1.ry = '0; bus1.imm = '0;
    bus3.valid = 1'b0; bus3.kind = 1'b0; bus3.op = '0; bus3.rd = '0; bus3.rx = '0; bus3.ry = '0; bus3.imm = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_chk = 1'b1;
    @(posedge clk); #1;

    // back-to-back LDIs
    send(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 16'd8888);
    send(1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 16'd5555);
    send(1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 16'd2321);
    send(1'b0, 2'd0, 2'd3, 2'd0, 2'd0, 16'd1234);
    stop();
    @(posedge clk); #1;
    dbg_addr1 = 2'd0; #1 chk("ldi_r0", dbg_data1, 16'd8888);
    dbg_addr1 = 2'd1; #1 chk("ldi_r1", dbg_data1, 16'd5555);
    dbg_addr1 = 2'd2; #1 chk("ldi_r2", dbg_data1, 16'd2321);
    dbg_addr1 = 2'd3; #1 chk("ldi_r3", dbg_data1, 16'd1234);

    // asynchronous reset asserted mid-cycle
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("rst_ready", bus1.ready, 0);
    chk("rst_wb_valid", wb_valid1, 0);
    chk("rst_wb_data", wb_data1, 0);
    chk("rst_alu_x", alu_x1, 0);
    chk("rst_dbg_r3", dbg_data1, 0);
    @(posedge clk); #1;
    chk("rst_ready_held", bus1.ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU add r2 = r0 + r1
    send(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 16'd8888);
    send(1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 16'd5555);
    send(1'b1, 2'd0, 2'd2, 2'd0, 2'd1, '0);
    stop();
    @(negedge clk);
    chk("issue_ena", alu_ena1, 1);
    chk("issue_x", alu_x1, 16'd8888);
    chk("issue_y", alu_y1, 16'd5555);
    chk("issue_op", alu_op1, 0);
    chk("issue_ready", bus1.ready, 0);
    @(negedge clk);
    chk("wait_ready", bus1.ready, 0);
    @(negedge clk);
    chk("wb_valid_lit", wb_valid1, 1);
    chk("wb_rd_lit", wb_rd1, 2);
    chk("wb_data_lit", wb_data1, 16'd14443);
    chk("wb_ready_lit", bus1.ready, 1);
    @(negedge clk);
    chk("wb_single_pulse", wb_valid1, 0);
    @(posedge clk); #1;

    // self-overwrite: r0 = r0 + r1
    send(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 16'd6546);
    send(1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 16'd234);
    send(1'b1, 2'd0, 2'd0, 2'd0, 2'd1, '0);
    stop();
    @(negedge clk);
    chk("self_x", alu_x1, 16'd6546);
    repeat (3) @(negedge clk);
    dbg_addr1 = 2'd0; #1 chk("self_r0", dbg_data1, 16'd6780);

    // reset pulse while the next instruction waits on the ALU
    @(posedge clk); #1;
    send(1'b1, 2'd0, 2'd3, 2'd0, 2'd1, '0);
    stop();
    @(posedge clk); #2 rst_n = 1'b0; #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstwait_wb", wb_valid1, 0);
      chk("rstwait_busy", busy1, 0);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr1 = 2'(i); #1 chk("rstwait_rf", dbg_data1, 0);
    end
    @(posedge clk); #1;

    // randomized stream, valid held across busy periods
    for (int n = 0; n < 300; n++) begin
      dbg_addr1 = 2'($urandom);
      send(1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), W'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        stop();
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    stop();
    repeat (6) @(posedge clk);
    #1;

    // ALU_LAT=3 build with ena low for two WAIT cycles
    bus3.valid = 1'b1; bus3.kind = 1'b0; bus3.rd = 2'd0; bus3.imm = 16'd8888;
    @(posedge clk); #1;
    bus3.rd = 2'd1; bus3.imm = 16'd5555;
    @(posedge clk); #1;
    bus3.kind = 1'b1; bus3.op = 2'd0; bus3.rd = 2'd2; bus3.rx = 2'd0; bus3.ry = 2'd1;
    chk("lat3_ready_pre", bus3.ready, 1);
    @(posedge clk); #1;
    bus3.valid = 1'b0;
    dbg_addr3 = 2'd2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("lat3_wb_valid", wb_valid3, W'(c == 6));
      chk("lat3_ready", bus3.ready, W'(c >= 6));
      chk("lat3_busy", busy3, W'(c < 6));
      chk("lat3_alu_ena", alu_ena3, W'(c == 0));
      if (c == 6) begin
        chk("lat3_wb_rd", wb_rd3, 2);
        chk("lat3_wb_data", wb_data3, 16'd14443);
      end
      @(posedge clk); #1;
      if (c + 1 == 2) ena3 = 1'b0;
      if (c + 1 == 4) ena3 = 1'b1;
    end
    chk("lat3_dbg_r2", dbg_data3, 16'd14443);

    run_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
